// File: rtl/noc_tg_pkg.sv
// noc_tg_pkg: shared types and field layout for the NoC traffic injector.
//   tg_state_e      : injector FSM state encoding
//   SEQ_W / IDX_W   : sequence-number and flit-index field widths
//   TS_W            : timestamp width (NOC_TG_TIMESTAMP_EN builds)
//   DEST_LSB        : head flit destination field offset
//   src_lsb()       : head flit source field offset for a given DEST_W
//   head_seq_lsb()  : head flit sequence field offset for a given DEST_W
//   IDX_LSB/SEQ_LSB : body flit index / sequence field offsets
package noc_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_GAP,
        ST_DONE
    } tg_state_e;

    localparam int unsigned SEQ_W    = 8;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned TS_W     = 32;

    localparam int unsigned DEST_LSB = 0;
    localparam int unsigned IDX_LSB  = 0;
    localparam int unsigned SEQ_LSB  = IDX_LSB + IDX_W;

    function automatic int unsigned src_lsb(input int unsigned dest_w);
        return DEST_LSB + dest_w;
    endfunction

    function automatic int unsigned head_seq_lsb(input int unsigned dest_w);
        return DEST_LSB + 2 * dest_w;
    endfunction

endpackage

// File: rtl/noc_traffic_injector_dest_sel.sv
// noc_dest_sel: holds the destination of the current packet.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : latch seed_i/mode_i and select the first destination
//   seed_i       : fixed destination / round-robin seed
//   mode_i       : 0 = fixed, 1 = round-robin (latched on load_i)
//   advance_i    : step to the next destination (round-robin only)
//   dest_o       : current destination
// Seeds >= NUM_NODES clamp to 0; the node's own SRC_ID is never selected.
module noc_dest_sel
    import noc_tg_pkg::*;
#(
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned NUM_NODES = 9,
    parameter int unsigned SRC_ID    = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DEST_W-1:0] seed_i,
    input  logic              mode_i,
    input  logic              advance_i,
    output logic [DEST_W-1:0] dest_o
);

    localparam logic [DEST_W:0]   NODES_N = (DEST_W + 1)'(NUM_NODES);
    localparam logic [DEST_W-1:0] SRC_V   = DEST_W'(SRC_ID);

    logic [DEST_W-1:0] dest_q;
    logic              mode_q;
    logic [DEST_W-1:0] clamped;

    function automatic logic [DEST_W-1:0] wrap_inc(input logic [DEST_W-1:0] x);
        logic [DEST_W:0] n;
        n = {1'b0, x} + (DEST_W + 1)'(1);
        if (n >= NODES_N) begin
            n = '0;
        end
        return n[DEST_W-1:0];
    endfunction

    function automatic logic [DEST_W-1:0] skip_self(input logic [DEST_W-1:0] x);
        return (x == SRC_V) ? wrap_inc(x) : x;
    endfunction

    always_comb begin
        clamped = ({1'b0, seed_i} >= NODES_N) ? '0 : seed_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dest_q <= '0;
            mode_q <= 1'b0;
        end else if (load_i) begin
            dest_q <= skip_self(clamped);
            mode_q <= mode_i;
        end else if (advance_i && mode_q) begin
            dest_q <= skip_self(wrap_inc(dest_q));
        end
    end

    assign dest_o = dest_q;

endmodule

// File: rtl/noc_traffic_injector.sv
// noc_traffic_injector: per-node multi-flit packet generator for one NoC
// local input port.
//   clk, rst     : clock, synchronous active-high reset
//   start        : launch request, honoured only in IDLE/DONE
//   mode         : 0 = fixed destination, 1 = round-robin
//   dest_cfg     : fixed destination / round-robin seed
//   num_packets  : packets to send (0 completes immediately)
//   gap_cfg      : idle cycles between packets
//   data_out     : flit to NoC
//   valid_out    : flit valid (never depends on ready_in)
//   ready_in     : NoC accepts flit
//   busy, done   : run status
//   pkt_sent     : packets whose tail was accepted (saturating)
// Optional macro NOC_TG_TIMESTAMP_EN: body flit 1 carries the free-running
// cycle count captured when the head flit transferred.
module noc_traffic_injector
    import noc_tg_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned NUM_NODES = 9,
    parameter int unsigned SRC_ID    = 0,
    parameter int unsigned FLITS     = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DEST_W-1:0] dest_cfg,
    input  logic [CNT_W-1:0]  num_packets,
    input  logic [CNT_W-1:0]  gap_cfg,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_sent
);

    localparam int unsigned       FI_W      = (FLITS > 2) ? $clog2(FLITS) : 1;
    localparam logic [FI_W-1:0]   LAST_FLIT = FI_W'(FLITS - 1);
    localparam int unsigned       SRC_LSB   = src_lsb(DEST_W);
    localparam int unsigned       HSEQ_LSB  = head_seq_lsb(DEST_W);
    localparam logic [DEST_W-1:0] SRC_V     = DEST_W'(SRC_ID);

    tg_state_e         state_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  gap_q;
    logic [CNT_W-1:0]  gap_cnt_q;
    logic [CNT_W-1:0]  pkt_idx_q;
    logic [CNT_W-1:0]  pkt_sent_q;
    logic [FI_W-1:0]   flit_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] data_d;
    logic [DEST_W-1:0] dest;
    logic [SEQ_W-1:0]  seq;

    logic fire;
    logic launch;
    logic is_tail;
    logic is_last_pkt;
    logic dest_load;
    logic dest_adv;

`ifdef NOC_TG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_ctr_q;
    logic [TS_W-1:0] ts_cap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_ctr_q <= '0;
        end else begin
            ts_ctr_q <= ts_ctr_q + TS_W'(1);
        end
    end
`endif

    assign fire        = valid_q && ready_in;
    assign launch      = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign is_tail     = (state_q == ST_BODY) && (flit_q == LAST_FLIT);
    assign is_last_pkt = (pkt_idx_q == num_q - CNT_W'(1));
    assign dest_load   = launch && (num_packets != '0);
    assign dest_adv    = fire && is_tail && !is_last_pkt;
    assign seq         = SEQ_W'(pkt_idx_q);

    noc_dest_sel #(
        .DEST_W    (DEST_W),
        .NUM_NODES (NUM_NODES),
        .SRC_ID    (SRC_ID)
    ) u_dest_sel (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (dest_load),
        .seed_i    (dest_cfg),
        .mode_i    (mode),
        .advance_i (dest_adv),
        .dest_o    (dest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            pkt_idx_q  <= '0;
            pkt_sent_q <= '0;
            flit_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef NOC_TG_TIMESTAMP_EN
            ts_cap_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        num_q      <= num_packets;
                        gap_q      <= gap_cfg;
                        pkt_idx_q  <= '0;
                        pkt_sent_q <= '0;
                        flit_q     <= '0;
                        if (num_packets == '0) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_HEAD;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_HEAD: begin
                    if (fire) begin
                        state_q <= ST_BODY;
                        flit_q  <= FI_W'(1);
`ifdef NOC_TG_TIMESTAMP_EN
                        ts_cap_q <= ts_ctr_q;
`endif
                    end
                end
                ST_BODY: begin
                    if (fire) begin
                        if (flit_q == LAST_FLIT) begin
                            if (pkt_sent_q != '1) begin
                                pkt_sent_q <= pkt_sent_q + CNT_W'(1);
                            end
                            flit_q <= '0;
                            if (is_last_pkt) begin
                                state_q <= ST_DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                pkt_idx_q <= pkt_idx_q + CNT_W'(1);
                                if (gap_q == '0) begin
                                    state_q <= ST_HEAD;
                                end else begin
                                    state_q   <= ST_GAP;
                                    valid_q   <= 1'b0;
                                    gap_cnt_q <= gap_q;
                                end
                            end
                        end else begin
                            flit_q <= flit_q + FI_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    // Counter is loaded with gap_cfg, so HEAD follows exactly
                    // gap_cfg idle cycles.
                    if (gap_cnt_q == CNT_W'(1)) begin
                        state_q <= ST_HEAD;
                        valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Flit content is decoded from registered state only; every field it
    // uses changes solely on a transfer, so data_out holds during a stall.
    always_comb begin
        data_d = '0;
        case (state_q)
            ST_HEAD: begin
                data_d[DEST_LSB +: DEST_W] = dest;
                data_d[SRC_LSB  +: DEST_W] = SRC_V;
                data_d[HSEQ_LSB +: SEQ_W]  = seq;
            end
            ST_BODY: begin
                data_d[IDX_LSB +: IDX_W] = IDX_W'(flit_q);
                data_d[SEQ_LSB +: SEQ_W] = seq;
`ifdef NOC_TG_TIMESTAMP_EN
                if (flit_q == FI_W'(1)) begin
                    data_d[TS_W-1:0] = ts_cap_q;
                end
`endif
            end
            default: begin
            end
        endcase
    end

    assign data_out  = data_d;
    assign valid_out = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkt_sent  = pkt_sent_q;

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Directed bench for noc_traffic_injector (default build, timestamp macro off).
// A second instance with NUM_NODES=4, SRC_ID=2 covers round-robin selection.
module tb_noc_traffic_injector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, mode, ready_in;
    logic [3:0]  dest_cfg;
    logic [15:0] num_packets, gap_cfg;
    logic [31:0] data_out;
    logic        valid_out, busy, done;
    logic [15:0] pkt_sent;

    logic        rr_start, rr_mode, rr_ready;
    logic [3:0]  rr_dest;
    logic [15:0] rr_num, rr_gap;
    logic [31:0] rr_data;
    logic        rr_valid, rr_busy, rr_done;
    logic [15:0] rr_pkt_sent;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    noc_traffic_injector u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .dest_cfg    (dest_cfg),
        .num_packets (num_packets),
        .gap_cfg     (gap_cfg),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .busy        (busy),
        .done        (done),
        .pkt_sent    (pkt_sent)
    );

    noc_traffic_injector #(
        .NUM_NODES (4),
        .SRC_ID    (2)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .start       (rr_start),
        .mode        (rr_mode),
        .dest_cfg    (rr_dest),
        .num_packets (rr_num),
        .gap_cfg     (rr_gap),
        .data_out    (rr_data),
        .valid_out   (rr_valid),
        .ready_in    (rr_ready),
        .busy        (rr_busy),
        .done        (rr_done),
        .pkt_sent    (rr_pkt_sent)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic launch(input logic m, input logic [3:0] d, input logic [15:0] n,
                          input logic [15:0] g);
        mode        = m;
        dest_cfg    = d;
        num_packets = n;
        gap_cfg     = g;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Head: {seq, src, dest}; body: {seq, index}.
    function automatic logic [31:0] flit_exp(input int unsigned p, input int unsigned i,
                                             input int unsigned d, input int unsigned s);
        if (i == 0) return 32'(((p % 256) << 8) | (s << 4) | d);
        return 32'(((p % 256) << 8) | i);
    endfunction

    int unsigned rr_dests[4] = '{1, 3, 0, 1};

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; ready_in = 1'b1;
        dest_cfg = '0; num_packets = '0; gap_cfg = '0;
        rr_start = 1'b0; rr_mode = 1'b0; rr_ready = 1'b1;
        rr_dest = '0; rr_num = '0; rr_gap = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sent", 32'(pkt_sent), 32'd0);
        rst = 1'b0;
        tick();

        // Zero packets: done the cycle after start, no flits.
        launch(1'b0, 4'd3, 16'd0, 16'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("zero_valid%0d", c), 32'(valid_out), 32'd0);
            tick();
        end

        // Fixed destination, 2 packets back-to-back; a start mid-run is ignored.
        launch(1'b0, 4'd3, 16'd2, 16'd0);
        check("fix_busy", 32'(busy), 32'd1);
        check("fix_done_clr", 32'(done), 32'd0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("fix_valid%0d", k), 32'(valid_out), 32'd1);
            check($sformatf("fix_data%0d", k), data_out, flit_exp(k / 6, k % 6, 3, 0));
            if (k == 3) begin
                start = 1'b1; dest_cfg = 4'd7; mode = 1'b1; num_packets = 16'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("fix_done", 32'(done), 32'd1);
        check("fix_busy_end", 32'(busy), 32'd0);
        check("fix_valid_end", 32'(valid_out), 32'd0);
        check("fix_sent", 32'(pkt_sent), 32'd2);

        // Backpressure: ready low for 5 cycles while flit 3 is offered.
        launch(1'b0, 4'd5, 16'd1, 16'd0);
        begin
            int unsigned n = 0;
            for (int c = 0; c < 40; c++) begin
                if (n == 6) break;
                ready_in = !(c >= 3 && c < 8);
                if (valid_out)
                    check($sformatf("bp_c%0d", c), data_out, flit_exp(0, n, 5, 0));
                if (valid_out && ready_in) n++;
                tick();
            end
            ready_in = 1'b1;
            check("bp_count", n, 32'd6);
            check("bp_done", 32'(done), 32'd1);
            check("bp_sent", 32'(pkt_sent), 32'd1);
        end

        // Gap of 3 idle cycles between packets.
        launch(1'b0, 4'd2, 16'd2, 16'd3);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("gap_v%0d", c), 32'(valid_out),
                  32'((c < 6) || (c >= 9 && c < 15)));
            if (c == 0) check("gap_head0", data_out, flit_exp(0, 0, 2, 0));
            if (c == 9) check("gap_head1", data_out, flit_exp(1, 0, 2, 0));
            tick();
        end
        check("gap_done", 32'(done), 32'd1);

        // Round-robin on the SRC_ID=2, NUM_NODES=4 instance: 1,3,0,1.
        rr_mode = 1'b1; rr_dest = 4'd1; rr_num = 16'd4; rr_gap = 16'd0; rr_start = 1'b1;
        tick();
        rr_start = 1'b0;
        begin
            int unsigned n = 0;
            for (int c = 0; c < 60 && n < 24; c++) begin
                if (rr_valid && rr_ready) begin
                    if (n % 6 == 0)
                        check($sformatf("rr_head%0d", n / 6), rr_data,
                              flit_exp(n / 6, 0, rr_dests[n / 6], 2));
                    n++;
                end
                tick();
            end
            check("rr_count", n, 32'd24);
            check("rr_sent", 32'(rr_pkt_sent), 32'd4);
            check("rr_done", 32'(rr_done), 32'd1);
        end

        // Reset during flit 3 of packet 1, then restart from seq 0.
        launch(1'b0, 4'd4, 16'd3, 16'd0);
        for (int j = 0; j < 9; j++) tick();
        check("mid_data", data_out, flit_exp(1, 3, 4, 0));
        check("mid_sent", 32'(pkt_sent), 32'd1);
        rst = 1'b1;
        tick();
        check("mrst_valid", 32'(valid_out), 32'd0);
        check("mrst_data", data_out, 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_sent", 32'(pkt_sent), 32'd0);
        rst = 1'b0;
        tick();
        launch(1'b0, 4'd4, 16'd1, 16'd0);
        check("restart_valid", 32'(valid_out), 32'd1);
        check("restart_head", data_out, flit_exp(0, 0, 4, 0));
        for (int j = 0; j < 6; j++) tick();
        check("restart_done", 32'(done), 32'd1);
        check("restart_sent", 32'(pkt_sent), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
